// File: rtl/debounce_multi.sv
// Multi-channel button debouncer: synchronise raw inputs, sample on a shared tick,
// accept level changes after consecutive stable samples, and pulse press/release/repeat.
module debounce_multi #(
    parameter int CHANNELS       = 4,
    parameter int TICK_DIV       = 90000,
    parameter int STABLE_SAMPLES = 20,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_PERIOD  = 100,
    parameter int ACTIVE_LOW     = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    output logic [CHANNELS-1:0] btn_repeat
);
    localparam int DIV_W     = $clog2(TICK_DIV);
    localparam int CNT_W     = $clog2(STABLE_SAMPLES + 1);
    localparam int HOLD_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W    = $clog2(HOLD_MAX + 1);
    localparam bit REPEAT_EN = (REPEAT_DELAY > 0);

    localparam logic [DIV_W-1:0]    DIV_LAST    = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]    CNT_LAST    = CNT_W'(STABLE_SAMPLES - 1);
    localparam logic [HOLD_W-1:0]   DELAY_LAST  = HOLD_W'(REPEAT_EN ? REPEAT_DELAY - 1 : 0);
    localparam logic [HOLD_W-1:0]   PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);
    localparam logic [CHANNELS-1:0] POL_MASK    = {CHANNELS{(ACTIVE_LOW != 0)}};

    logic [DIV_W-1:0]    div_q, div_d;
    logic                tick;
    logic [CHANNELS-1:0] meta_q, sync_q;
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] press_q, press_d;
    logic [CHANNELS-1:0] release_q, release_d;
    logic [CHANNELS-1:0] repeat_q, repeat_d;
    logic [CHANNELS-1:0] rpt_q, rpt_d;
    logic [CHANNELS-1:0] accept;
    logic [CNT_W-1:0]    cnt_q  [CHANNELS];
    logic [CNT_W-1:0]    cnt_d  [CHANNELS];
    logic [HOLD_W-1:0]   hold_q [CHANNELS];
    logic [HOLD_W-1:0]   hold_d [CHANNELS];

    assign tick  = (div_q == DIV_LAST);
    assign div_d = tick ? '0 : div_q + DIV_W'(1);

    // A change is accepted on the tick that would complete STABLE_SAMPLES disagreeing samples.
    always_comb begin
        accept = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            accept[i] = tick && (sync_q[i] != level_q[i]) && (cnt_q[i] == CNT_LAST);
            if (!tick) begin
                cnt_d[i] = cnt_q[i];
            end else if ((sync_q[i] == level_q[i]) || accept[i]) begin
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign level_d   = level_q ^ accept;
    assign press_d   = accept & ~level_q;
    assign release_d = accept & level_q;

    // rpt_q selects the first-repeat delay or the steady repeat period as the hold target.
    always_comb begin
        repeat_d = '0;
        rpt_d    = rpt_q;
        for (int i = 0; i < CHANNELS; i++) begin
            hold_d[i] = hold_q[i];
            if (!level_q[i] || accept[i]) begin
                hold_d[i] = '0;
                rpt_d[i]  = 1'b0;
            end else if (REPEAT_EN && tick) begin
                if (hold_q[i] == (rpt_q[i] ? PERIOD_LAST : DELAY_LAST)) begin
                    repeat_d[i] = 1'b1;
                    hold_d[i]   = '0;
                    rpt_d[i]    = 1'b1;
                end else begin
                    hold_d[i] = hold_q[i] + HOLD_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            meta_q    <= '0;
            sync_q    <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            repeat_q  <= '0;
            rpt_q     <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]  <= '0;
                hold_q[i] <= '0;
            end
        end else begin
            div_q     <= div_d;
            meta_q    <= btn_in ^ POL_MASK;
            sync_q    <= meta_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            rpt_q     <= rpt_d;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]  <= cnt_d[i];
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_repeat  = repeat_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: a cycle model pushes expected outputs per clock into a queue,
// popped and compared at the following falling edge, plus directed scenario checks.
module tb_debounce_multi;
    localparam int CH = 4;
    localparam int TD = 4;
    localparam int SS = 3;
    localparam int RD = 5;
    localparam int RP = 2;
    localparam int AL = 0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] btn_in;
    logic [CH-1:0] lvl, prs, rel, rep;

    debounce_multi #(
        .CHANNELS(CH), .TICK_DIV(TD), .STABLE_SAMPLES(SS),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .ACTIVE_LOW(AL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
        .btn_level(lvl), .btn_press(prs), .btn_release(rel), .btn_repeat(rep)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    int            m_div;
    logic [CH-1:0] m_s1, m_s2, m_lvl;
    int            m_cnt  [CH];
    int            m_hold [CH];
    bit            m_rpt  [CH];
    logic [4*CH-1:0] exp_q [$];

    always @(posedge clk or negedge rst_n) begin : model
        logic [CH-1:0] p, r, rp;
        bit tk, flip;
        if (!rst_n) begin
            m_div = 0;
            m_s1  = '0;
            m_s2  = '0;
            m_lvl = '0;
            for (int c = 0; c < CH; c++) begin
                m_cnt[c]  = 0;
                m_hold[c] = 0;
                m_rpt[c]  = 1'b0;
            end
            exp_q.delete();
        end else begin
            tk = (m_div == TD - 1);
            p  = '0;
            r  = '0;
            rp = '0;
            for (int c = 0; c < CH; c++) begin
                flip = 1'b0;
                if (tk) begin
                    if (m_s2[c] == m_lvl[c]) m_cnt[c] = 0;
                    else if (m_cnt[c] + 1 == SS) begin
                        flip     = 1'b1;
                        m_cnt[c] = 0;
                    end else m_cnt[c] = m_cnt[c] + 1;
                end
                if (!m_lvl[c]) begin
                    m_hold[c] = 0;
                    m_rpt[c]  = 1'b0;
                end else if (tk && RD > 0) begin
                    m_hold[c] = m_hold[c] + 1;
                    if (m_hold[c] == (m_rpt[c] ? RP : RD)) begin
                        m_hold[c] = 0;
                        m_rpt[c]  = 1'b1;
                        if (!flip) rp[c] = 1'b1;
                    end
                end
                if (flip) begin
                    if (m_lvl[c]) r[c] = 1'b1;
                    else          p[c] = 1'b1;
                    m_lvl[c] = ~m_lvl[c];
                end
            end
            exp_q.push_back({m_lvl, p, r, rp});
            m_s2  = m_s1;
            m_s1  = btn_in ^ {CH{(AL != 0)}};
            m_div = tk ? 0 : m_div + 1;
        end
    end

    int cyc = 0;
    bit sb_on = 1'b0;
    int npress [CH];
    int nrel   [CH];
    int nrep   [CH];
    int rep2_t [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        logic [4*CH-1:0] e;
        if (sb_on && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scoreboard", 32'({lvl, prs, rel, rep}), 32'(e));
        end
        if (sb_on && (|(prs | rel | rep)))
            check("exclusive", 32'((prs & rel) | (prs & rep) | (rel & rep)), 0);
        for (int c = 0; c < CH; c++) begin
            if (prs[c] === 1'b1) npress[c]++;
            if (rel[c] === 1'b1) nrel[c]++;
            if (rep[c] === 1'b1) begin
                nrep[c]++;
                if (c == 2) rep2_t.push_back(cyc);
            end
        end
    end

    function automatic int total_pulses();
        int s = 0;
        for (int c = 0; c < CH; c++) s += npress[c] + nrel[c] + nrep[c];
        return s;
    endfunction

    // kind: 0 press, 1 release, 2 repeat; a timeout is reported as a failed comparison
    task automatic wait_pulse(input int ch, input int kind, input int maxc,
                              input string tag, output int at);
        logic [CH-1:0] v;
        at = -1;
        for (int k = 0; k < maxc; k++) begin
            @(negedge clk);
            v = (kind == 0) ? prs : (kind == 1) ? rel : rep;
            if (v[ch] === 1'b1) begin
                at = cyc;
                break;
            end
        end
        check({tag, "_seen"}, 32'(at >= 0), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, at, s0, n0, n1, pp, rr;

        // reset asserted mid-cycle while all buttons are held
        rst_n  = 1'b1;
        btn_in = '1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_async", 32'({lvl, prs, rel, rep}), 0);
        sb_on = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_hold", 32'({lvl, prs, rel, rep}), 0);
        @(negedge clk);
        btn_in = '0;
        #2 rst_n = 1'b1;
        s0 = total_pulses();
        repeat (100) @(negedge clk);
        check("idle_pulses", total_pulses() - s0, 0);
        check("idle_level", 32'(lvl), 0);

        // clean press on channel 0
        btn_in[0] = 1'b1;
        t0 = cyc;
        wait_pulse(0, 0, 20, "p2_press", at);
        check("p2_latency_ok", 32'((at - t0) >= 11 && (at - t0) <= 15), 1);
        check("p2_level", 32'(lvl[0]), 1);
        check("p2_others_quiet", 32'(prs[3:1]), 0);
        @(negedge clk);
        check("p2_width", 32'(prs[0]), 0);
        check("p2_count", npress[0], 1);

        // bouncing press on channel 1, then a one-tick glitch low
        n0 = npress[1];
        for (int k = 0; k < 13; k++) begin
            repeat (3) @(negedge clk);
            btn_in[1] = ~btn_in[1];
        end
        check("p3_bounce_silent", npress[1] - n0, 0);
        wait_pulse(1, 0, 16, "p3_press", at);
        repeat (3) @(negedge clk);
        n1 = nrel[1];
        btn_in[1] = 1'b0;
        repeat (4) @(negedge clk);
        btn_in[1] = 1'b1;
        repeat (16) @(negedge clk);
        check("p3_glitch_norel", nrel[1] - n1, 0);
        check("p3_glitch_level", 32'(lvl[1]), 1);
        check("p3_press_count", npress[1] - n0, 1);

        // clean release on channel 1
        btn_in[1] = 1'b0;
        t0 = cyc;
        wait_pulse(1, 1, 16, "p4_release", at);
        check("p4_latency_ok", 32'((at - t0) >= 11 && (at - t0) <= 15), 1);
        check("p4_level", 32'(lvl[1]), 0);
        check("p4_no_rep_at_rel", 32'(rep[1]), 0);
        n1 = nrep[1];
        repeat (30) @(negedge clk);
        check("p4_no_rep_after", nrep[1] - n1, 0);

        // auto-repeat on channel 2: first at 5 ticks (20 clk), then every 2 ticks (8 clk)
        btn_in[2] = 1'b1;
        wait_pulse(2, 0, 16, "p5_press", pp);
        repeat (56) @(negedge clk);
        check("p5_nrep_ge5", 32'(rep2_t.size() >= 5), 1);
        if (rep2_t.size() >= 5) begin
            check("p5_first", rep2_t[0] - pp, 20);
            for (int k = 1; k < 5; k++) check("p5_gap", rep2_t[k] - rep2_t[k-1], 8);
        end
        btn_in[2] = 1'b0;
        wait_pulse(2, 1, 16, "p5_release", rr);
        check("p5_no_rep_at_rel", 32'(rep[2]), 0);
        n1 = rep2_t.size();
        repeat (40) @(negedge clk);
        check("p5_stop", rep2_t.size() - n1, 0);

        // simultaneous press on channels 0 and 3, then reset while held
        btn_in[0] = 1'b0;
        wait_pulse(0, 1, 16, "p6_rel0", at);
        repeat (10) @(negedge clk);
        btn_in[0] = 1'b1;
        btn_in[3] = 1'b1;
        wait_pulse(0, 0, 16, "p6_press0", at);
        check("p6_same_cycle", 32'(prs[3]), 1);
        repeat (5) @(negedge clk);
        n0 = nrel[0] + nrel[3];
        n1 = npress[0] + npress[3];
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("p6_rst_async", 32'({lvl, prs, rel, rep}), 0);
        repeat (3) @(negedge clk);
        check("p6_rst_hold", 32'({lvl, prs, rel, rep}), 0);
        #2 rst_n = 1'b1;
        wait_pulse(0, 0, 15, "p6_repress0", at);
        check("p6_repress3", 32'(prs[3]), 1);
        repeat (20) @(negedge clk);
        check("p6_no_release", (nrel[0] + nrel[3]) - n0, 0);
        check("p6_press_count", (npress[0] + npress[3]) - n1, 2);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
